rojobot_app_if: RTL and testbench
=================================

ROJOBOT_APP_IF -- requirements
Module: rojobot_app_if

Interface
REQ-001 SHALL have parameter PORT_BASE, default 8'h00: base port_id of the register window.
REQ-002 SHALL have parameter BOTCFG_INIT, default 8'h00: reset value of Bot_Config_out.
REQ-003 SHALL have port clk  input  1  system clock; all state is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port upd_sysregs  input  1  update flag from the BOTSIM; may be high for one or more cycles.
REQ-006 SHALL have ports LocX_in, LocY_in, Sensors_in, BotInfo_in, LMDist_in, RMDist_in  input  8 each  live BOTSIM registers.
REQ-007 SHALL have port port_id  input  8  application PicoBlaze port address.
REQ-008 SHALL have port out_port  input  8  application PicoBlaze write data.
REQ-009 SHALL have ports write_strobe and read_strobe  input  1 each  application PicoBlaze strobes.
REQ-010 SHALL have port in_port  output  8  read data to the application PicoBlaze.
REQ-011 SHALL have port interrupt  output  1  interrupt request to the application PicoBlaze.
REQ-012 SHALL have port interrupt_ack  input  1  interrupt acknowledge from the application PicoBlaze.
REQ-013 SHALL have port MotCtl_out  output  8  motor control byte to the BOTSIM.
REQ-014 SHALL have port Bot_Config_out  output  8  BOTSIM configuration byte.

Function
REQ-015 SHALL register upd_sysregs and detect its rising edge; each rising edge is one update event, regardless of pulse width.
REQ-016 On an update event, SHALL copy all six *_in values into shadow registers on the same clock edge the event is detected; the shadows stay unchanged otherwise.
REQ-017 SHALL implement an interrupt FSM with two states:
- IDLE: interrupt = 0.
- PEND: interrupt = 1.
REQ-018 IDLE -> PEND on an update event; PEND -> IDLE on interrupt_ack with no update event in the same cycle; PEND stays PEND otherwise.
REQ-019 If an update event and interrupt_ack occur in the same cycle, SHALL remain in or enter PEND, so the new event wins.
REQ-020 On an update event while in PEND, SHALL still refresh the shadows and SHALL increment an 8-bit overrun counter, saturating at 8'hFF.
REQ-021 Read map, by offset from PORT_BASE:
- 0 to 5: shadow LocX, LocY, Sensors, BotInfo, LMDist, RMDist.
- 6: status {interrupt, upd_sysregs_sync, 6'b0}.
- 7: overrun counter.
- Any other port_id: 8'h00.
REQ-022 in_port SHALL be registered: it is updated every clock from port_id, with one cycle of latency, independent of read_strobe.
REQ-023 A read_strobe at offset 7 SHALL clear the overrun counter on that edge; if an overrun occurs in the same cycle, the counter becomes 1.
REQ-024 write_strobe at offset 8 SHALL load MotCtl_out from out_port.
REQ-025 write_strobe at offset 9 SHALL load Bot_Config_out from out_port.
REQ-026 Writes to any other port SHALL be ignored.
REQ-027 Offset arithmetic SHALL be 8-bit modulo; a window that wraps past 8'hFF SHALL decode correctly.

Reset
REQ-028 While reset = 0, SHALL immediately force:
- FSM to IDLE, interrupt = 0.
- Shadows = 0, overrun counter = 0, in_port = 0.
- MotCtl_out = 0 (stop), Bot_Config_out = BOTCFG_INIT.
- Edge-detect register = 0.
REQ-029 An upd_sysregs that is already high when reset releases SHALL count as one update event on the first clock edge after release.
REQ-030 Reset asserted in PEND SHALL drop interrupt and discard the pending event.

Verification
REQ-031 Reset release, no stimulus -> interrupt 0, MotCtl_out 00, Bot_Config_out = BOTCFG_INIT; reads of offsets 0 to 7 return 00.
REQ-032 LocX_in=0x2A, upd_sysregs pulsed high for 3 cycles -> exactly one event, interrupt 1, offset 0 returns 2A one cycle after port_id is set, overrun counter 0.
REQ-033 Two events without ack -> overrun counter 1; read_strobe at offset 7 -> returns 01, then 00; an overrun in the clear cycle -> 01.
REQ-034 Event coincident with interrupt_ack while in PEND -> interrupt stays 1; a later lone ack -> interrupt 0.
REQ-035 write_strobe at offset 8 with out_port=0x33, then at offset 9 with 0x05 -> MotCtl_out 33, Bot_Config_out 05; a write to offset 10 changes nothing.
REQ-036 256 or more overruns -> counter holds FF; reset asserted mid-PEND -> interrupt 0 with no clock edge required.

Source files
------------

// File: rtl/rojobot_app_if.sv
// Application-side register window between a BOTSIM and its application PicoBlaze.
// It latches BOTSIM snapshots on each update edge, raises an interrupt and exposes the motor and config registers.
module rojobot_app_if #(
   parameter logic [7:0] PORT_BASE   = 8'h00,
   parameter logic [7:0] BOTCFG_INIT = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       upd_sysregs,
   input  logic [7:0] LocX_in,
   input  logic [7:0] LocY_in,
   input  logic [7:0] Sensors_in,
   input  logic [7:0] BotInfo_in,
   input  logic [7:0] LMDist_in,
   input  logic [7:0] RMDist_in,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   output logic [7:0] MotCtl_out,
   output logic [7:0] Bot_Config_out
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } irq_state_t;

   localparam int unsigned NUM_SHADOWS = 6;

   localparam logic [7:0] OFF_STATUS  = 8'd6;
   localparam logic [7:0] OFF_OVERRUN = 8'd7;
   localparam logic [7:0] OFF_MOTCTL  = 8'd8;
   localparam logic [7:0] OFF_BOTCFG  = 8'd9;

   irq_state_t state_q, state_d;
   logic       upd_sync_q, upd_sync_d;
   logic [7:0] shadow_q [NUM_SHADOWS];
   logic [7:0] shadow_d [NUM_SHADOWS];
   logic [7:0] overrun_q, overrun_d;
   logic [7:0] in_port_q, in_port_d;
   logic [7:0] motctl_q, motctl_d;
   logic [7:0] botcfg_q, botcfg_d;

   logic [7:0] offset;
   logic       upd_event;
   logic       overrun_event;
   logic [7:0] live_in [NUM_SHADOWS];

   assign live_in[0] = LocX_in;
   assign live_in[1] = LocY_in;
   assign live_in[2] = Sensors_in;
   assign live_in[3] = BotInfo_in;
   assign live_in[4] = LMDist_in;
   assign live_in[5] = RMDist_in;

   // Wrapping subtraction lets a window based near 8'hFF decode across the rollover.
   assign offset        = port_id - PORT_BASE;
   assign upd_event     = upd_sysregs & ~upd_sync_q;
   assign overrun_event = upd_event && (state_q == PEND);

   // Interrupt FSM: a fresh update always wins over a coincident acknowledge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (upd_event) state_d = PEND;
         PEND:    if (!upd_event && interrupt_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: every variable gets its default first so no path can infer a latch.
   always_comb begin
      upd_sync_d = upd_sysregs;
      shadow_d   = shadow_q;
      overrun_d  = overrun_q;
      motctl_d   = motctl_q;
      botcfg_d   = botcfg_q;
      in_port_d  = 8'h00;

      if (upd_event) shadow_d = live_in;

      if (read_strobe && (offset == OFF_OVERRUN)) begin
         overrun_d = overrun_event ? 8'h01 : 8'h00;
      end else if (overrun_event && (overrun_q != 8'hFF)) begin
         overrun_d = overrun_q + 8'h01;
      end

      if (write_strobe) begin
         if (offset == OFF_MOTCTL) motctl_d = out_port;
         if (offset == OFF_BOTCFG) botcfg_d = out_port;
      end

      if (offset < OFF_STATUS) begin
         in_port_d = shadow_q[offset[2:0]];
      end else if (offset == OFF_STATUS) begin
         in_port_d = {(state_q == PEND), upd_sync_q, 6'b000000};
      end else if (offset == OFF_OVERRUN) begin
         in_port_d = overrun_q;
      end
   end

   // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         upd_sync_q <= 1'b0;
         for (int i = 0; i < NUM_SHADOWS; i++) shadow_q[i] <= 8'h00;
         overrun_q  <= 8'h00;
         in_port_q  <= 8'h00;
         motctl_q   <= 8'h00;
         botcfg_q   <= BOTCFG_INIT;
      end else begin
         state_q    <= state_d;
         upd_sync_q <= upd_sync_d;
         shadow_q   <= shadow_d;
         overrun_q  <= overrun_d;
         in_port_q  <= in_port_d;
         motctl_q   <= motctl_d;
         botcfg_q   <= botcfg_d;
      end
   end

   assign interrupt      = (state_q == PEND);
   assign in_port        = in_port_q;
   assign MotCtl_out     = motctl_q;
   assign Bot_Config_out = botcfg_q;

endmodule

// File: tb/tb_rojobot_app_if.sv
// Self-checking bench for rojobot_app_if with a wrapping register window and a behavioural model.
// Directed scenarios run first, then a randomized soak against the model.
module tb_rojobot_app_if;

   localparam logic [7:0] BASE = 8'hFC;
   localparam logic [7:0] CFG0 = 8'hA5;

   logic       clk = 1'b0;
   logic       reset;
   logic       upd_sysregs;
   logic [7:0] LocX_in, LocY_in, Sensors_in, BotInfo_in, LMDist_in, RMDist_in;
   logic [7:0] port_id, out_port;
   logic       write_strobe, read_strobe, interrupt_ack;
   logic [7:0] in_port, MotCtl_out, Bot_Config_out;
   logic       interrupt;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [7:0] m_sh [6];
   bit         m_pend;
   int         m_ovr;
   bit         m_prev_upd;
   logic [7:0] m_rd, m_mot, m_cfg;

   rojobot_app_if #(.PORT_BASE(BASE), .BOTCFG_INIT(CFG0)) dut (
      .clk(clk), .reset(reset), .upd_sysregs(upd_sysregs),
      .LocX_in(LocX_in), .LocY_in(LocY_in), .Sensors_in(Sensors_in),
      .BotInfo_in(BotInfo_in), .LMDist_in(LMDist_in), .RMDist_in(RMDist_in),
      .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .read_strobe(read_strobe),
      .in_port(in_port), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
      .MotCtl_out(MotCtl_out), .Bot_Config_out(Bot_Config_out)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_sh[i] = 8'h00;
      m_pend = 0; m_ovr = 0; m_prev_upd = 0;
      m_rd = 8'h00; m_mot = 8'h00; m_cfg = CFG0;
   endtask

   // Advance the model by one clock using the current inputs, then let the DUT take the same edge.
   task automatic tick();
      bit evt;
      logic [7:0] off;
      evt = upd_sysregs && !m_prev_upd;
      off = port_id - BASE;
      if (off < 6)       m_rd = m_sh[off];
      else if (off == 6) m_rd = {m_pend, m_prev_upd, 6'b0};
      else if (off == 7) m_rd = m_ovr[7:0];
      else               m_rd = 8'h00;
      if (read_strobe && off == 7) m_ovr = (evt && m_pend) ? 1 : 0;
      else if (evt && m_pend && m_ovr < 255) m_ovr = m_ovr + 1;
      if (evt) begin
         m_sh[0] = LocX_in;    m_sh[1] = LocY_in;   m_sh[2] = Sensors_in;
         m_sh[3] = BotInfo_in; m_sh[4] = LMDist_in; m_sh[5] = RMDist_in;
      end
      if (evt) m_pend = 1;
      else if (interrupt_ack) m_pend = 0;
      if (write_strobe && off == 8) m_mot = out_port;
      if (write_strobe && off == 9) m_cfg = out_port;
      m_prev_upd = upd_sysregs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      upd_sysregs = 0; write_strobe = 0; read_strobe = 0; interrupt_ack = 0;
      out_port = 8'h00; port_id = 8'h00;
   endtask

   task automatic apply_reset(input bit upd_at_release);
      @(posedge clk); #1;
      reset = 0;
      model_reset();
      idle_inputs();
      upd_sysregs = upd_at_release;
      @(posedge clk); @(posedge clk); #1;
      reset = 1;
   endtask

   task automatic test_reset();
      apply_reset(0);
      tick();
      checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", interrupt); end
      checks++; if (MotCtl_out !== 8'h00) begin failures++; $display("FAIL reset_motctl got=%h exp=00", MotCtl_out); end
      checks++; if (Bot_Config_out !== CFG0) begin failures++; $display("FAIL reset_botcfg got=%h exp=%h", Bot_Config_out, CFG0); end
      for (int i = 0; i < 8; i++) begin
         port_id = BASE + 8'(i);
         tick();
         checks++;
         if (in_port !== 8'h00) begin failures++; $display("FAIL reset_read off=%0d got=%h exp=00", i, in_port); end
      end
   endtask

   task automatic test_update_pulse();
      LocX_in = 8'h2A; LocY_in = 8'h11; Sensors_in = 8'h22;
      BotInfo_in = 8'h33; LMDist_in = 8'h44; RMDist_in = 8'h55;
      upd_sysregs = 1;
      repeat (3) tick();
      upd_sysregs = 0;
      tick();
      checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL pulse_irq got=%b exp=1", interrupt); end
      port_id = BASE;
      tick();
      checks++; if (in_port !== 8'h2A) begin failures++; $display("FAIL pulse_locx got=%h exp=2a", in_port); end
      port_id = BASE + 8'd5;
      tick();
      checks++; if (in_port !== 8'h55) begin failures++; $display("FAIL pulse_rmdist got=%h exp=55", in_port); end
      port_id = BASE + 8'd7;
      tick();
      checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL pulse_overrun got=%h exp=00", in_port); end
      port_id = BASE + 8'd6;
      tick();
      checks++; if (in_port !== 8'h80) begin failures++; $display("FAIL pulse_status got=%h exp=80", in_port); end
   endtask

   task automatic test_overrun();
      upd_sysregs = 1; tick(); upd_sysregs = 0; tick();
      port_id = BASE + 8'd7;
      tick();
      checks++; if (in_port !== 8'h01) begin failures++; $display("FAIL ovr_one got=%h exp=01", in_port); end
      read_strobe = 1; tick(); read_strobe = 0;
      checks++; if (in_port !== 8'h01) begin failures++; $display("FAIL ovr_read got=%h exp=01", in_port); end
      tick();
      checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL ovr_cleared got=%h exp=00", in_port); end
      read_strobe = 1; upd_sysregs = 1; tick();
      read_strobe = 0; upd_sysregs = 0; tick();
      checks++; if (in_port !== 8'h01) begin failures++; $display("FAIL ovr_clear_race got=%h exp=01", in_port); end
   endtask

   task automatic test_ack_collision();
      upd_sysregs = 1; interrupt_ack = 1; tick();
      upd_sysregs = 0; interrupt_ack = 0;
      checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL collide_irq got=%b exp=1", interrupt); end
      interrupt_ack = 1; tick(); interrupt_ack = 0;
      checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL lone_ack got=%b exp=0", interrupt); end
      tick();
      checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL idle_hold got=%b exp=0", interrupt); end
   endtask

   task automatic test_writes();
      write_strobe = 1;
      port_id = BASE + 8'd8; out_port = 8'h33; tick();
      port_id = BASE + 8'd9; out_port = 8'h05; tick();
      port_id = BASE + 8'd10; out_port = 8'h77; tick();
      write_strobe = 0;
      checks++; if (MotCtl_out !== 8'h33) begin failures++; $display("FAIL wr_motctl got=%h exp=33", MotCtl_out); end
      checks++; if (Bot_Config_out !== 8'h05) begin failures++; $display("FAIL wr_botcfg got=%h exp=05", Bot_Config_out); end
      port_id = BASE + 8'd8; out_port = 8'h99; tick();
      checks++; if (MotCtl_out !== 8'h33) begin failures++; $display("FAIL wr_nostrobe got=%h exp=33", MotCtl_out); end
   endtask

   task automatic test_saturation_and_reset();
      upd_sysregs = 1; tick(); upd_sysregs = 0; tick();
      repeat (260) begin
         upd_sysregs = 1; tick(); upd_sysregs = 0; tick();
      end
      port_id = BASE + 8'd7;
      tick();
      checks++; if (in_port !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%h exp=ff", in_port); end
      checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL sat_pend got=%b exp=1", interrupt); end
      #2;
      reset = 0;
      model_reset();
      #1;
      checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL async_rst_irq got=%b exp=0", interrupt); end
      checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL async_rst_inport got=%h exp=00", in_port); end
      checks++; if (Bot_Config_out !== CFG0) begin failures++; $display("FAIL async_rst_cfg got=%h exp=%h", Bot_Config_out, CFG0); end
      @(posedge clk); #1;
      reset = 1;
      tick();
      checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL post_rst_overrun got=%h exp=00", in_port); end
      checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL post_rst_irq got=%b exp=0", interrupt); end
   endtask

   task automatic test_reset_release_high();
      LocY_in = 8'h6D;
      apply_reset(1);
      port_id = BASE + 8'd1;
      tick();
      checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL release_high_irq got=%b exp=1", interrupt); end
      tick();
      checks++; if (in_port !== 8'h6D) begin failures++; $display("FAIL release_high_shadow got=%h exp=6d", in_port); end
      port_id = BASE + 8'd7;
      tick(); tick();
      checks++; if (in_port !== 8'h00) begin failures++; $display("FAIL release_high_once got=%h exp=00", in_port); end
      upd_sysregs = 0;
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         upd_sysregs   = ($urandom_range(0, 3) == 0);
         interrupt_ack = ($urandom_range(0, 4) == 0);
         read_strobe   = ($urandom_range(0, 3) == 0);
         write_strobe  = ($urandom_range(0, 3) == 0);
         out_port      = 8'($urandom);
         port_id       = ($urandom_range(0, 7) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 11));
         LocX_in = 8'($urandom); LocY_in = 8'($urandom); Sensors_in = 8'($urandom);
         BotInfo_in = 8'($urandom); LMDist_in = 8'($urandom); RMDist_in = 8'($urandom);
         tick();
         checks++;
         if ({interrupt, in_port, MotCtl_out, Bot_Config_out} !== {m_pend, m_rd, m_mot, m_cfg}) begin
            failures++;
            $display("FAIL rand_%0d got irq=%b in=%h mot=%h cfg=%h exp irq=%b in=%h mot=%h cfg=%h",
                     n, interrupt, in_port, MotCtl_out, Bot_Config_out, m_pend, m_rd, m_mot, m_cfg);
         end
      end
      idle_inputs();
   endtask

   initial begin
      reset = 0;
      idle_inputs();
      LocX_in = 0; LocY_in = 0; Sensors_in = 0; BotInfo_in = 0; LMDist_in = 0; RMDist_in = 0;
      model_reset();
      test_reset();
      test_update_pulse();
      test_overrun();
      test_ack_collision();
      test_writes();
      test_saturation_and_reset();
      test_reset_release_high();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
